// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one small FIFO per producer (ALU, LSB), LSB-first grant
// with an ALU anti-starvation guard, registered broadcast, flush on mispredict.
module cdb_arbiter #(
    parameter int ROB_BIT    = 4,
    parameter int DAT_W      = 32,
    parameter int ADR_W      = 17,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               alu_en_i,
    input  logic [ROB_BIT-1:0] alu_q_i,
    input  logic [DAT_W-1:0]   alu_v_i,
    input  logic               alu_cbr_i,
    input  logic [ADR_W-1:0]   alu_cbt_i,
    output logic               alu_rdy_o,
    input  logic               lsb_en_i,
    input  logic [ROB_BIT-1:0] lsb_q_i,
    input  logic [DAT_W-1:0]   lsb_v_i,
    output logic               lsb_rdy_o,
    input  logic               br_flag_i,
    output logic               cdb_en_o,
    output logic [ROB_BIT-1:0] cdb_q_o,
    output logic [DAT_W-1:0]   cdb_v_o,
    output logic               cdb_cbr_o,
    output logic [ADR_W-1:0]   cdb_cbt_o,
    output logic               cdb_src_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ST_W-1:0]  ST_MAX  = ST_W'(STARVE_MAX);

    typedef struct packed {
        logic [ROB_BIT-1:0] q;
        logic [DAT_W-1:0]   v;
        logic               cbr;
        logic [ADR_W-1:0]   cbt;
    } alu_ent_t;

    typedef struct packed {
        logic [ROB_BIT-1:0] q;
        logic [DAT_W-1:0]   v;
    } lsb_ent_t;

    alu_ent_t alu_mem [FIFO_DEPTH];
    lsb_ent_t lsb_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]   alu_rptr_q, alu_rptr_d, alu_wptr_q, alu_wptr_d;
    logic [PTR_W-1:0]   lsb_rptr_q, lsb_rptr_d, lsb_wptr_q, lsb_wptr_d;
    logic [CNT_W-1:0]   alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
    logic [ST_W-1:0]    starve_q, starve_d;
    logic               cdb_en_q, cdb_en_d;
    logic [ROB_BIT-1:0] cdb_q_q, cdb_q_d;
    logic [DAT_W-1:0]   cdb_v_q, cdb_v_d;
    logic               cdb_cbr_q, cdb_cbr_d;
    logic [ADR_W-1:0]   cdb_cbt_q, cdb_cbt_d;
    logic               cdb_src_q, cdb_src_d;

    logic     alu_rdy, lsb_rdy, flush;
    logic     alu_push, lsb_push, alu_has, lsb_has, alu_cand, lsb_cand;
    logic     grant_alu, grant_lsb, alu_pop, lsb_pop, alu_wr, lsb_wr;
    alu_ent_t alu_in, alu_head;
    lsb_ent_t lsb_in, lsb_head;

    assign alu_rdy   = alu_cnt_q < DEPTH_C;
    assign lsb_rdy   = lsb_cnt_q < DEPTH_C;
    assign alu_rdy_o = rst & alu_rdy;
    assign lsb_rdy_o = rst & lsb_rdy;

    assign flush    = en & br_flag_i;
    assign alu_push = en & ~br_flag_i & alu_en_i & alu_rdy;
    assign lsb_push = en & ~br_flag_i & lsb_en_i & lsb_rdy;
    assign alu_has  = alu_cnt_q != '0;
    assign lsb_has  = lsb_cnt_q != '0;
    assign alu_in   = '{q: alu_q_i, v: alu_v_i, cbr: alu_cbr_i, cbt: alu_cbt_i};
    assign lsb_in   = '{q: lsb_q_i, v: lsb_v_i};

    // An empty FIFO offers the live input directly so a lone result takes one cycle.
    assign alu_cand = alu_has | alu_push;
    assign lsb_cand = lsb_has | lsb_push;
    assign alu_head = alu_has ? alu_mem[alu_rptr_q] : alu_in;
    assign lsb_head = lsb_has ? lsb_mem[lsb_rptr_q] : lsb_in;

    assign grant_alu = alu_cand & (~lsb_cand | (starve_q == ST_MAX));
    assign grant_lsb = lsb_cand & ~grant_alu;
    assign alu_pop   = grant_alu & alu_has;
    assign lsb_pop   = grant_lsb & lsb_has;
    // A bypassed winner never touches the FIFO storage.
    assign alu_wr    = alu_push & (~grant_alu | alu_has);
    assign lsb_wr    = lsb_push & (~grant_lsb | lsb_has);

    always_comb begin
        alu_rptr_d = alu_rptr_q + PTR_W'(alu_pop);
        alu_wptr_d = alu_wptr_q + PTR_W'(alu_wr);
        lsb_rptr_d = lsb_rptr_q + PTR_W'(lsb_pop);
        lsb_wptr_d = lsb_wptr_q + PTR_W'(lsb_wr);
        alu_cnt_d  = alu_cnt_q + CNT_W'(alu_wr) - CNT_W'(alu_pop);
        lsb_cnt_d  = lsb_cnt_q + CNT_W'(lsb_wr) - CNT_W'(lsb_pop);
        starve_d   = '0;
        cdb_en_d   = 1'b0;
        cdb_q_d    = cdb_q_q;
        cdb_v_d    = cdb_v_q;
        cdb_cbr_d  = cdb_cbr_q;
        cdb_cbt_d  = cdb_cbt_q;
        cdb_src_d  = cdb_src_q;

        if (alu_cand && grant_lsb)
            starve_d = (starve_q == ST_MAX) ? starve_q : starve_q + ST_W'(1);

        if (grant_alu) begin
            cdb_en_d  = 1'b1;
            cdb_q_d   = alu_head.q;
            cdb_v_d   = alu_head.v;
            cdb_cbr_d = alu_head.cbr;
            cdb_cbt_d = alu_head.cbt;
            cdb_src_d = 1'b0;
        end else if (grant_lsb) begin
            cdb_en_d  = 1'b1;
            cdb_q_d   = lsb_head.q;
            cdb_v_d   = lsb_head.v;
            cdb_cbr_d = 1'b0;
            cdb_cbt_d = '0;
            cdb_src_d = 1'b1;
        end

        if (flush) begin
            alu_rptr_d = '0;
            alu_wptr_d = '0;
            lsb_rptr_d = '0;
            lsb_wptr_d = '0;
            alu_cnt_d  = '0;
            lsb_cnt_d  = '0;
            starve_d   = '0;
            cdb_en_d   = 1'b0;
            cdb_q_d    = cdb_q_q;
            cdb_v_d    = cdb_v_q;
            cdb_cbr_d  = cdb_cbr_q;
            cdb_cbt_d  = cdb_cbt_q;
            cdb_src_d  = cdb_src_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_rptr_q <= '0;
            alu_wptr_q <= '0;
            lsb_rptr_q <= '0;
            lsb_wptr_q <= '0;
            alu_cnt_q  <= '0;
            lsb_cnt_q  <= '0;
            starve_q   <= '0;
            cdb_en_q   <= 1'b0;
            cdb_q_q    <= '0;
            cdb_v_q    <= '0;
            cdb_cbr_q  <= 1'b0;
            cdb_cbt_q  <= '0;
            cdb_src_q  <= 1'b0;
        end else if (en) begin
            alu_rptr_q <= alu_rptr_d;
            alu_wptr_q <= alu_wptr_d;
            lsb_rptr_q <= lsb_rptr_d;
            lsb_wptr_q <= lsb_wptr_d;
            alu_cnt_q  <= alu_cnt_d;
            lsb_cnt_q  <= lsb_cnt_d;
            starve_q   <= starve_d;
            cdb_en_q   <= cdb_en_d;
            cdb_q_q    <= cdb_q_d;
            cdb_v_q    <= cdb_v_d;
            cdb_cbr_q  <= cdb_cbr_d;
            cdb_cbt_q  <= cdb_cbt_d;
            cdb_src_q  <= cdb_src_d;
        end
    end

    // Storage needs no reset: only entries below the count are ever read.
    always_ff @(posedge clk) begin
        if (alu_wr) alu_mem[alu_wptr_q] <= alu_in;
        if (lsb_wr) lsb_mem[lsb_wptr_q] <= lsb_in;
    end

    assign cdb_en_o  = cdb_en_q;
    assign cdb_q_o   = cdb_q_q;
    assign cdb_v_o   = cdb_v_q;
    assign cdb_cbr_o = cdb_cbr_q;
    assign cdb_cbt_o = cdb_cbt_q;
    assign cdb_src_o = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized scoreboard bench for cdb_arbiter: a queue-based reference model predicts
// the bus contents for every cycle; a monitor compares them at the falling edge.
module tb_cdb_arbiter;
    localparam int RB = 4, DW = 32, AW = 17, D = 4, SM = 3;

    logic          clk = 1'b0, rst = 1'b0, en = 1'b0;
    logic          alu_en_i = 1'b0, alu_cbr_i = 1'b0, lsb_en_i = 1'b0, br_flag_i = 1'b0;
    logic [RB-1:0] alu_q_i = '0, lsb_q_i = '0;
    logic [DW-1:0] alu_v_i = '0, lsb_v_i = '0;
    logic [AW-1:0] alu_cbt_i = '0;
    logic          alu_rdy_o, lsb_rdy_o, cdb_en_o, cdb_cbr_o, cdb_src_o;
    logic [RB-1:0] cdb_q_o;
    logic [DW-1:0] cdb_v_o;
    logic [AW-1:0] cdb_cbt_o;

    cdb_arbiter #(.ROB_BIT(RB), .DAT_W(DW), .ADR_W(AW), .FIFO_DEPTH(D), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst), .en(en),
        .alu_en_i(alu_en_i), .alu_q_i(alu_q_i), .alu_v_i(alu_v_i),
        .alu_cbr_i(alu_cbr_i), .alu_cbt_i(alu_cbt_i), .alu_rdy_o(alu_rdy_o),
        .lsb_en_i(lsb_en_i), .lsb_q_i(lsb_q_i), .lsb_v_i(lsb_v_i), .lsb_rdy_o(lsb_rdy_o),
        .br_flag_i(br_flag_i),
        .cdb_en_o(cdb_en_o), .cdb_q_o(cdb_q_o), .cdb_v_o(cdb_v_o),
        .cdb_cbr_o(cdb_cbr_o), .cdb_cbt_o(cdb_cbt_o), .cdb_src_o(cdb_src_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [RB-1:0] q;
        logic [DW-1:0] v;
        logic          cbr;
        logic [AW-1:0] cbt;
    } ent_t;

    typedef struct {
        int            cyc;
        logic          en;
        logic [RB-1:0] q;
        logic [DW-1:0] v;
        logic          cbr;
        logic [AW-1:0] cbt;
        logic          src;
    } out_t;

    ent_t a_src[$], l_src[$];   // producer backlog not yet accepted
    ent_t aq[$], lq[$];         // results accepted but not yet broadcast
    out_t exp_q[$];
    out_t m_out = '{default: 0};
    int   starve = 0;
    int   errors = 0, checks = 0;

    function automatic ent_t mk(input int q, input bit is_alu);
        ent_t x;
        x.q   = q[RB-1:0];
        x.v   = $urandom;
        x.cbr = is_alu ? 1'($urandom_range(0, 1)) : 1'b0;
        x.cbt = is_alu ? AW'($urandom) : '0;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        out_t e;
        if (rst && exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            if (cdb_en_o)
                $display("cyc %0d cdb q=%0d v=%08h cbr=%0d cbt=%05h src=%0d",
                         cyc, cdb_q_o, cdb_v_o, cdb_cbr_o, cdb_cbt_o, cdb_src_o);
            chk($sformatf("cdb_cyc%0d", cyc),
                {8'h0, cdb_en_o, cdb_q_o, cdb_v_o, cdb_cbr_o, cdb_cbt_o, cdb_src_o},
                {8'h0, e.en, e.q, e.v, e.cbr, e.cbt, e.src});
        end
    end

    // One bus cycle: drive offers, then advance the reference model by the rules.
    task automatic step(input logic e, input logic br, input logic oa, input logic ol);
        logic a_off, l_off, a_acc, l_acc, ac, lc, aw;
        ent_t ea, el, x;
        @(negedge clk);
        chk("alu_rdy", 64'(alu_rdy_o), 64'(aq.size() < D));
        chk("lsb_rdy", 64'(lsb_rdy_o), 64'(lsb_q_size_lt()));
        a_off = oa && a_src.size() > 0;
        l_off = ol && l_src.size() > 0;
        ea = a_off ? a_src[0] : mk(0, 1'b1);
        el = l_off ? l_src[0] : mk(0, 1'b0);
        en = e; br_flag_i = br;
        alu_en_i = a_off; alu_q_i = ea.q; alu_v_i = ea.v; alu_cbr_i = ea.cbr; alu_cbt_i = ea.cbt;
        lsb_en_i = l_off; lsb_q_i = el.q; lsb_v_i = el.v;
        if (e) begin
            if (br) begin
                aq.delete(); lq.delete();
                starve = 0;
                m_out.en = 1'b0;
            end else begin
                a_acc = a_off && aq.size() < D;
                l_acc = l_off && lq.size() < D;
                if (a_acc) begin aq.push_back(ea); void'(a_src.pop_front()); end
                if (l_acc) begin lq.push_back(el); void'(l_src.pop_front()); end
                ac = aq.size() > 0;
                lc = lq.size() > 0;
                aw = ac && (!lc || starve == SM);
                if (aw) begin
                    x = aq.pop_front();
                    m_out.en = 1'b1; m_out.q = x.q; m_out.v = x.v;
                    m_out.cbr = x.cbr; m_out.cbt = x.cbt; m_out.src = 1'b0;
                end else if (lc) begin
                    x = lq.pop_front();
                    m_out.en = 1'b1; m_out.q = x.q; m_out.v = x.v;
                    m_out.cbr = 1'b0; m_out.cbt = '0; m_out.src = 1'b1;
                end else begin
                    m_out.en = 1'b0;
                end
                if (ac && lc && !aw) starve = (starve < SM) ? starve + 1 : SM;
                else                 starve = 0;
            end
        end
        m_out.cyc = cyc + 1;
        exp_q.push_back(m_out);
    endtask

    function automatic bit lsb_q_size_lt();
        return lq.size() < D;
    endfunction

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        alu_en_i = 1'b0; lsb_en_i = 1'b0; br_flag_i = 1'b0; en = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_cdb", {8'h0, cdb_en_o, cdb_q_o, cdb_v_o, cdb_cbr_o, cdb_cbt_o, cdb_src_o}, 64'h0);
        chk("rst_alu_rdy", 64'(alu_rdy_o), 64'h0);
        chk("rst_lsb_rdy", 64'(lsb_rdy_o), 64'h0);
        exp_q.delete(); aq.delete(); lq.delete(); a_src.delete(); l_src.delete();
        starve = 0;
        m_out = '{default: 0};
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        ent_t t;
        int   n, tag;
        @(negedge clk);
        chk("por_cdb", {8'h0, cdb_en_o, cdb_q_o, cdb_v_o, cdb_cbr_o, cdb_cbt_o, cdb_src_o}, 64'h0);
        chk("por_alu_rdy", 64'(alu_rdy_o), 64'h0);
        chk("por_lsb_rdy", 64'(lsb_rdy_o), 64'h0);
        #2 rst = 1'b1;
        idle(2);

        // lone ALU result bypasses its FIFO
        t = mk(3, 1'b1); t.v = 32'h1234; t.cbr = 1'b1; t.cbt = 17'h00100;
        a_src.push_back(t);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);

        // simultaneous arrival: LSB first
        a_src.push_back(mk(1, 1'b1));
        l_src.push_back(mk(2, 1'b0));
        step(1'b1, 1'b0, 1'b1, 1'b1);
        idle(3);

        // ALU forced through after STARVE_MAX losses
        a_src.push_back(mk(5, 1'b1));
        for (int i = 8; i < 16; i++) l_src.push_back(mk(i, 1'b0));
        repeat (14) step(1'b1, 1'b0, 1'b1, 1'b1);
        idle(4);

        // backpressure on the ALU FIFO under a continuous LSB stream
        for (int i = 0; i < 7; i++) a_src.push_back(mk(i, 1'b1));
        for (int i = 0; i < 24; i++) l_src.push_back(mk(i % 16, 1'b0));
        n = 0;
        while ((a_src.size() > 0 || l_src.size() > 0) && n < 100) begin
            step(1'b1, 1'b0, 1'b1, 1'b1);
            n++;
        end
        idle(12);

        // flush with live push, then stall with a push pending
        for (int i = 0; i < 4; i++) begin
            a_src.push_back(mk(i, 1'b1));
            l_src.push_back(mk(8 + i, 1'b0));
        end
        repeat (4) step(1'b1, 1'b0, 1'b1, 1'b1);
        a_src.delete(); l_src.delete();
        a_src.push_back(mk(9, 1'b1));
        step(1'b1, 1'b1, 1'b1, 1'b0);
        a_src.delete();
        @(negedge clk);
        chk("flush_alu_rdy", 64'(alu_rdy_o), 64'h1);
        chk("flush_lsb_rdy", 64'(lsb_rdy_o), 64'h1);
        a_src.push_back(mk(6, 1'b1));
        step(1'b1, 1'b0, 1'b1, 1'b0);
        a_src.push_back(mk(7, 1'b1));
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);

        // random traffic with stalls and flushes
        tag = 0;
        repeat (400) begin
            if (a_src.size() < 2) a_src.push_back(mk(tag, 1'b1));
            if (l_src.size() < 2) l_src.push_back(mk(tag + 3, 1'b0));
            tag++;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
        end
        a_src.delete(); l_src.delete();
        idle(12);

        // asynchronous reset while the ALU FIFO holds entries
        for (int i = 0; i < 3; i++) begin
            a_src.push_back(mk(i, 1'b1));
            l_src.push_back(mk(10 + i, 1'b0));
        end
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1);
        do_reset();
        idle(2);
        a_src.push_back(mk(1, 1'b1));
        l_src.push_back(mk(2, 1'b0));
        step(1'b1, 1'b0, 1'b1, 1'b1);
        idle(3);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
